// File: rtl/edf_label_tagger.sv
// EDF label tagger: stamps each descriptor with an absolute deadline (now + per-flow deadline) and
// spaces heap pushes to leave room for sift. Optional clamp of labels under `LABEL_SATURATE_EN.
module edf_label_tagger #(
    parameter int                     ADDR_WIDTH       = 9,
    parameter int                     DATA_WIDTH       = 16,
    parameter int                     LABEL_WIDTH      = 8,
    parameter int                     FLOW_WIDTH       = 2,
    parameter logic [LABEL_WIDTH-1:0] DEFAULT_DEADLINE = LABEL_WIDTH'(16),
    parameter int                     SIFT_GAP         = ADDR_WIDTH + 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FLOW_WIDTH-1:0]             in_flow,
    input  logic [DATA_WIDTH-LABEL_WIDTH-1:0] in_payload,
    input  logic                              tick,
    input  logic                              cfg_we,
    input  logic [FLOW_WIDTH-1:0]             cfg_flow,
    input  logic [LABEL_WIDTH-1:0]            cfg_deadline,
    input  logic                              heap_re,
    output logic                              heap_we,
    output logic [DATA_WIDTH-1:0]             heap_din,
    output logic [LABEL_WIDTH-1:0]            now,
    output logic [ADDR_WIDTH:0]               occupancy,
    output logic                              full,
    output logic                              err_underflow
);

    localparam int GAP_WIDTH = $clog2(SIFT_GAP + 1);
    localparam int FLOWS     = 2 ** FLOW_WIDTH;
    localparam logic [ADDR_WIDTH:0] OCC_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic {IDLE, PEND} state_t;

    state_t                  state_q;
    logic [LABEL_WIDTH-1:0]  now_q;
    logic [GAP_WIDTH-1:0]    gap_q, gap_d;
    logic [ADDR_WIDTH:0]     occ_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    err_q;
    logic [LABEL_WIDTH-1:0]  table_q [FLOWS];
    logic [LABEL_WIDTH-1:0]  deadline;
    logic [LABEL_WIDTH-1:0]  label_d;
    logic                    accept;
    logic                    push;

    assign deadline = table_q[in_flow];

`ifdef LABEL_SATURATE_EN
    // All-ones stays reserved as the heap's empty marker, so clamp one below it.
    localparam logic [LABEL_WIDTH:0] LABEL_CAP = (LABEL_WIDTH+1)'(2 ** LABEL_WIDTH - 2);
    logic [LABEL_WIDTH:0] label_sum;
    assign label_sum = {1'b0, now_q} + {1'b0, deadline};
    assign label_d   = (label_sum > LABEL_CAP) ? LABEL_CAP[LABEL_WIDTH-1:0]
                                               : label_sum[LABEL_WIDTH-1:0];
`else
    assign label_d = now_q + deadline;
`endif

    assign full     = (occ_q == OCC_MAX);
    assign in_ready = (state_q == IDLE) && !full && !heap_re;
    assign accept   = in_valid && in_ready;
    // A pop owns the heap for its cycle; the push waits rather than using the replace path.
    assign push     = (state_q == PEND) && (gap_q == '0) && !heap_re;

    assign heap_we       = push;
    assign heap_din      = din_q;
    assign now           = now_q;
    assign occupancy     = occ_q;
    assign err_underflow = err_q;

    always_comb begin
        gap_d = gap_q;
        if (push || heap_re) begin
            gap_d = GAP_WIDTH'(SIFT_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            now_q   <= '0;
            gap_q   <= '0;
            occ_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < FLOWS; i++) begin
                table_q[i] <= DEFAULT_DEADLINE;
            end
        end else begin
            gap_q <= gap_d;
            if (tick) begin
                now_q <= now_q + LABEL_WIDTH'(1);
            end
            if (cfg_we) begin
                table_q[cfg_flow] <= cfg_deadline;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= PEND;
                        din_q   <= {label_d, in_payload};
                    end
                end
                PEND: begin
                    if (push) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (push) begin
                occ_q <= occ_q + (ADDR_WIDTH+1)'(1);
            end else if (heap_re) begin
                if (occ_q != '0) begin
                    occ_q <= occ_q - (ADDR_WIDTH+1)'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule
